// File: rtl/aes_pkg.sv
// Shared constants and index helpers for the Rijndael ShiftRows datapath.
// Byte s[r][c] of a state lives at byte lane 4*c + r.
package aes_pkg;

    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_st_e;

    function automatic bit nb_legal(input int nb);
        return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
    endfunction

    // Only the 256-bit block widens the offsets of rows 2 and 3.
    function automatic int shift_off(input int nb, input int row);
        case (row)
            0:       return 0;
            1:       return 1;
            2:       return (nb == NB_256) ? 3 : 2;
            default: return (nb == NB_256) ? 4 : 3;
        endcase
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Source columns are fixed at elaboration; only a 2:1 mux per byte remains.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic              mode,
    input  logic [32*NB-1:0]  state_in,
    output logic [32*NB-1:0]  state_out
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF = shift_off(NB, r);
            localparam int ENC = (c + OFF) % NB;
            localparam int DEC = (c - OFF + NB) % NB;
            assign state_out[8*byte_idx(r, c) +: 8] = mode
                ? state_in[8*byte_idx(r, DEC) +: 8]
                : state_in[8*byte_idx(r, ENC) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage with a DEPTH-entry output FIFO; the permutation is applied
// on the way in, so a result is visible the cycle after acceptance.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [32*NB-1:0]  in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [32*NB-1:0]  out_state
);

    localparam int W  = 32 * NB;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]    DEPTH_C = 3'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    if (!nb_legal(NB) || DEPTH < 1 || DEPTH > 4) begin : g_bad_param
        $error("shift_rows_pipe: illegal NB=%0d or DEPTH=%0d", NB, DEPTH);
    end

    logic [W-1:0]  perm;
    logic [W-1:0]  mem_st [DEPTH];
    logic          mem_md [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    count;
    fifo_st_e      st;
    logic          push, pop;

    shift_rows_perm #(.NB(NB)) u_perm (
        .mode      (in_mode),
        .state_in  (in_state),
        .state_out (perm)
    );

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        st = PARTIAL;
        if (count == 3'd0)
            st = EMPTY;
        else if (count == DEPTH_C)
            st = FULL;
    end

    // Handshake flags come from the registered count only.
    assign in_ready  = (st != FULL);
    assign out_valid = (st != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Clearing storage keeps out_state/out_mode at zero until a push.
            for (int i = 0; i < DEPTH; i++) begin
                mem_st[i] <= '0;
                mem_md[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_st[wr_ptr] <= perm;
                mem_md[wr_ptr] <= in_mode;
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_state = mem_st[rd_ptr];
    assign out_mode  = mem_md[rd_ptr];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Randomised and directed checks of shift_rows_pipe at NB=4 and NB=8 against
// a byte-level ShiftRows model and a queue model of the output buffer.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv4, ir4, im4, ov4, or4, om4;
    logic [127:0] is4, os4;
    logic         iv8, ir8, im8, ov8, or8, om8;
    logic [255:0] is8, os8;

    shift_rows_pipe #(.NB(4), .DEPTH(2)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_mode(im4), .in_state(is4),
        .out_valid(ov4), .out_ready(or4), .out_mode(om4), .out_state(os4)
    );

    shift_rows_pipe #(.NB(8), .DEPTH(2)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_mode(im8), .in_state(is8),
        .out_valid(ov8), .out_ready(or8), .out_mode(om8), .out_state(os8)
    );

    typedef struct {
        bit           m;
        logic [255:0] s;
    } ent_t;

    ent_t q4[$];
    ent_t q8[$];
    int   nchk  = 0;
    int   nfail = 0;

    // out[r][c] = in[r][(c +/- off_r) mod nb], byte s[r][c] at lane 4c+r.
    function automatic logic [255:0] ref_shift(input logic [255:0] v, input int nb, input bit m);
        int           off [4];
        int           src;
        logic [255:0] o;
        o = '0;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                src = m ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                o[8*(4*c+r) +: 8] = v[8*(4*src+r) +: 8];
            end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check current outputs against the queue models, then advance one edge.
    task automatic cyc();
        bit   p4, pp4, p8, pp8;
        ent_t e4, e8;
        chk("in_ready4",  256'(ir4), 256'(q4.size() < 2));
        chk("out_valid4", 256'(ov4), 256'(q4.size() > 0));
        if (q4.size() > 0) begin
            chk("out_state4", 256'(os4), q4[0].s);
            chk("out_mode4",  256'(om4), 256'(q4[0].m));
        end
        chk("in_ready8",  256'(ir8), 256'(q8.size() < 2));
        chk("out_valid8", 256'(ov8), 256'(q8.size() > 0));
        if (q8.size() > 0) begin
            chk("out_state8", os8, q8[0].s);
            chk("out_mode8",  256'(om8), 256'(q8[0].m));
        end
        p4   = iv4 && (q4.size() < 2);
        pp4  = or4 && (q4.size() > 0);
        p8   = iv8 && (q8.size() < 2);
        pp8  = or8 && (q8.size() > 0);
        e4.m = im4;
        e4.s = ref_shift({128'b0, is4}, 4, im4);
        e8.m = im8;
        e8.s = ref_shift(is8, 8, im8);
        @(posedge clk);
        #1;
        if (rst) begin
            q4.delete();
            q8.delete();
        end else begin
            if (pp4) void'(q4.pop_front());
            if (p4)  q4.push_back(e4);
            if (pp8) void'(q8.pop_front());
            if (p8)  q8.push_back(e8);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [7:0]   kin  [16];
        logic [7:0]   kout [16];
        logic [127:0] vin, vout, va, vb, vc;
        logic [255:0] v8;
        kin  = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                 8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
        kout = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
        for (int k = 0; k < 16; k++) begin
            vin[8*k +: 8]  = kin[k];
            vout[8*k +: 8] = kout[k];
        end
        for (int k = 0; k < 32; k++) v8[8*k +: 8] = 8'(k);

        rst = 1'b1;
        iv4 = 0; im4 = 0; is4 = '0; or4 = 0;
        iv8 = 0; im8 = 0; is8 = '0; or8 = 0;
        @(posedge clk);
        #1;
        cyc();
        rst = 1'b0;
        chk("rst_out_state4", 256'(os4), '0);
        chk("rst_out_mode4",  256'(om4), '0);
        chk("rst_out_state8", os8, '0);

        // Known-answer encrypt then decrypt at NB=4.
        is4 = vin; im4 = 0; iv4 = 1;
        cyc();
        iv4 = 0;
        chk("kat_enc_valid", 256'(ov4), 256'(1));
        chk("kat_enc_state", 256'(os4), 256'(vout));
        or4 = 1;
        cyc();
        or4 = 0;
        is4 = vout; im4 = 1; iv4 = 1;
        cyc();
        iv4 = 0;
        chk("kat_dec_state", 256'(os4), 256'(vin));
        chk("kat_dec_mode",  256'(om4), 256'(1));
        or4 = 1;
        cyc();
        or4 = 0;

        // NB=8 byte ramp, then decrypt the result with a same-edge push/pop.
        is8 = v8; im8 = 0; iv8 = 1;
        cyc();
        chk("nb8_r3c0", 256'(os8[8*3 +: 8]), 256'(8'h13));
        chk("nb8_r2c0", 256'(os8[8*2 +: 8]), 256'(8'h0e));
        chk("nb8_r1c0", 256'(os8[8*1 +: 8]), 256'(8'h05));
        is8 = ref_shift(v8, 8, 1'b0); im8 = 1; or8 = 1;
        cyc();
        iv8 = 0;
        chk("nb8_dec_state", os8, v8);
        chk("nb8_dec_mode",  256'(om8), 256'(1));
        cyc();
        or8 = 0;

        // Backpressure: two accepted, third held until space appears.
        va = rnd128(); vb = rnd128(); vc = rnd128();
        iv4 = 1; im4 = 0; is4 = va;
        cyc();
        chk("bp_ready_after1", 256'(ir4), 256'(1));
        is4 = vb; im4 = 1;
        cyc();
        chk("bp_ready_after2", 256'(ir4), 256'(0));
        is4 = vc; im4 = 0;
        cyc();
        chk("bp_head_held", 256'(os4), ref_shift({128'b0, va}, 4, 1'b0));
        or4 = 1;
        cyc();
        cyc();
        iv4 = 0;
        chk("bp_third_out", 256'(os4), ref_shift({128'b0, vc}, 4, 1'b0));
        cyc();
        cyc();
        or4 = 0;

        // Continuous stream with alternating modes.
        iv4 = 1; or4 = 1;
        for (int i = 0; i < 40; i++) begin
            is4 = rnd128();
            im4 = i[0];
            cyc();
        end
        iv4 = 0;
        cyc();
        cyc();

        // Random handshakes on both instances.
        for (int i = 0; i < 120; i++) begin
            iv4 = 1'($urandom); or4 = 1'($urandom); im4 = 1'($urandom); is4 = rnd128();
            iv8 = 1'($urandom); or8 = 1'($urandom); im8 = 1'($urandom);
            is8 = {rnd128(), rnd128()};
            cyc();
        end
        iv4 = 0; iv8 = 0; or4 = 1; or8 = 1;
        for (int i = 0; i < 4; i++) cyc();
        chk("drain_empty4", 256'(q4.size()), '0);
        chk("drain_empty8", 256'(q8.size()), '0);

        // Reset while full with a push offered at the same edge.
        or4 = 0; iv4 = 1; im4 = 1;
        is4 = rnd128();
        cyc();
        is4 = rnd128();
        cyc();
        is4 = rnd128();
        rst = 1;
        cyc();
        rst = 0; iv4 = 0; or4 = 1;
        chk("rst_full_valid", 256'(ov4), 256'(0));
        chk("rst_full_ready", 256'(ir4), 256'(1));
        chk("rst_full_state", 256'(os4), '0);
        chk("rst_full_mode",  256'(om4), '0);
        for (int i = 0; i < 4; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
